// File: rtl/sha3_job_pkg.sv
// Shared types and sizes for the SHA3 job sequencer and its result streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro: SHA3_JOB_SEQUENCER_HASH_READBACK_EN.
package sha3_job_pkg;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_REPORT    = 3'd4
    } seq_state_t;

    localparam int JOB_WORDS        = 26;
    localparam int BLOCK_WORDS      = 24;
    localparam int RESULT_HDR_WORDS = 3;
    localparam int HASH_WORDS       = 50;
    localparam int STATUS_FOUND_BIT = 0;

`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
    localparam int RESULT_WORDS = RESULT_HDR_WORDS + HASH_WORDS;
`else
    localparam int RESULT_WORDS = RESULT_HDR_WORDS;
`endif

endpackage

// File: rtl/sha3_result_streamer.sv
// Streams the result record (status, nonce, elapsed, optional hash) to the host.
// Latency: first word valid the cycle after i_cmpl; then one word per cycle.
// Backpressure: res_data/res_last registered and held while valid & ~ready.
// Optional hash words built only with SHA3_JOB_SEQUENCER_HASH_READBACK_EN.
module sha3_result_streamer
    import sha3_job_pkg::*;
#(
    parameter logic [31:0] MISS_NONCE = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmpl,
    input  logic        i_found,
    input  logic [31:0] i_nonce,
    input  logic [31:0] i_elapsed,
`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
    input  logic [HASH_WORDS-1:0][31:0] i_hash,
`endif
    input  logic        i_res_ready,
    output logic        o_res_valid,
    output logic [31:0] o_res_data,
    output logic        o_res_last,
    output logic        o_done
);

    localparam logic [5:0] LAST_IDX = 6'(RESULT_WORDS - 1);

    logic [5:0]  r_idx;
    logic        r_found;
    logic [31:0] r_nonce;
    logic [5:0]  w_idx;
    logic        w_found;
    logic [31:0] w_nonce;
    logic [31:0] w_word;

`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
    logic [HASH_WORDS-1:0][31:0] r_hash;

    // Snapshot the scanner hash at completion so readback is immune to a new scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hash <= '0;
        end else if (i_cmpl) begin
            r_hash <= i_hash;
        end
    end
`endif

    // Select the next word to load: W0 comes straight from the completion inputs.
    always_comb begin
        w_found = i_cmpl ? i_found : r_found;
        w_nonce = i_cmpl ? i_nonce : r_nonce;
        w_idx   = i_cmpl ? 6'd0 : (r_idx + 6'd1);
        w_word  = '0;
        case (w_idx)
            6'd0:    w_word[STATUS_FOUND_BIT] = w_found;
            6'd1:    w_word = w_found ? w_nonce : MISS_NONCE;
            6'd2:    w_word = i_elapsed;
`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
            default: w_word = r_hash[w_idx - 6'd3];
`else
            default: w_word = '0;
`endif
        endcase
    end

    // Output register and word index; advances only on an accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_res_valid <= 1'b0;
            o_res_last  <= 1'b0;
            o_res_data  <= '0;
            r_idx       <= '0;
            r_found     <= 1'b0;
            r_nonce     <= '0;
        end else if (i_cmpl) begin
            o_res_valid <= 1'b1;
            o_res_last  <= 1'b0;
            o_res_data  <= w_word;
            r_idx       <= 6'd0;
            r_found     <= i_found;
            r_nonce     <= i_nonce;
        end else if (o_res_valid && i_res_ready) begin
            if (o_res_last) begin
                o_res_valid <= 1'b0;
                o_res_last  <= 1'b0;
                o_res_data  <= '0;
            end else begin
                r_idx      <= w_idx;
                o_res_data <= w_word;
                o_res_last <= (w_idx == LAST_IDX);
            end
        end
    end

    assign o_done = o_res_valid & i_res_ready & o_res_last;

endmodule

// File: rtl/sha3_job_sequencer.sv
// Loads a 26-word job, starts the SHA3 scanner, times the scan and reports the result.
// Latency: scn_start the cycle after word 25; result valid the cycle after completion.
// Backpressure: job_ready only in LOAD; result words held until res_ready.
// Optional hash readback: SHA3_JOB_SEQUENCER_HASH_READBACK_EN.
module sha3_job_sequencer
    import sha3_job_pkg::*;
#(
    parameter logic [31:0] MISS_NONCE = 32'hFFFFFFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [31:0]                   job_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [31:0]                   res_data,
    output logic                          res_last,
    output logic                          busy,
    output logic                          scn_start,
    output logic [63:0]                   scn_threshold,
    output logic [BLOCK_WORDS-1:0][31:0]  scn_blobby,
    input  logic                          scn_dispatching,
    input  logic                          scn_evaluating,
    input  logic                          scn_found,
    input  logic                          scn_ready,
    input  logic [31:0]                   scn_nonce,
    input  logic [HASH_WORDS-1:0][31:0]   scn_hash
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [4:0]  r_k;
    logic [31:0] r_elapsed;
    logic        w_capture;
    logic        w_cmpl;
    logic        w_res_done;
    logic        w_unused_ok;

`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
    assign w_unused_ok = scn_evaluating;
`else
    assign w_unused_ok = ^{scn_evaluating, scn_hash};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and scanner start; the post-capture ready pulse is ignored in WAIT_BUSY.
    always_comb begin
        w_state_nxt = r_state;
        scn_start   = 1'b0;
        w_capture   = 1'b0;
        w_cmpl      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (job_valid && (r_k == 5'(JOB_WORDS - 1))) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                scn_start = scn_ready;
                if (scn_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (scn_dispatching) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (scn_ready && !scn_dispatching) begin
                    w_cmpl      = 1'b1;
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (w_res_done) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Job capture: block words then threshold halves; only written in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k           <= '0;
            scn_blobby    <= '0;
            scn_threshold <= '0;
        end else if ((r_state == ST_LOAD) && job_valid) begin
            if (r_k < 5'(BLOCK_WORDS)) begin
                scn_blobby[r_k] <= job_data;
            end else if (r_k == 5'(BLOCK_WORDS)) begin
                scn_threshold[31:0] <= job_data;
            end else begin
                scn_threshold[63:32] <= job_data;
            end
            r_k <= r_k + 5'd1;
        end else if ((r_state == ST_REPORT) && w_res_done) begin
            r_k <= '0;
        end
    end

    // Elapsed scan cycles, cleared at capture and saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_elapsed <= '0;
        end else if (w_capture) begin
            r_elapsed <= '0;
        end else if (((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) &&
                     (r_elapsed != 32'hFFFFFFFF)) begin
            r_elapsed <= r_elapsed + 32'd1;
        end
    end

    assign job_ready = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_LOAD) || (r_k != 5'd0);

    sha3_result_streamer #(
        .MISS_NONCE (MISS_NONCE)
    ) u_streamer (
        .clk         (clk),
        .rst         (rst),
        .i_cmpl      (w_cmpl),
        .i_found     (scn_found),
        .i_nonce     (scn_nonce),
        .i_elapsed   (r_elapsed),
`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
        .i_hash      (scn_hash),
`endif
        .i_res_ready (res_ready),
        .o_res_valid (res_valid),
        .o_res_data  (res_data),
        .o_res_last  (res_last),
        .o_done      (w_res_done)
    );

endmodule

// File: tb/tb_sha3_job_sequencer.sv
// Directed bench for sha3_job_sequencer with a behavioural scanner stub.
module tb_sha3_job_sequencer;

`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
    localparam int NW = 53;
`else
    localparam int NW = 3;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 job_valid;
    logic                 job_ready;
    logic [31:0]          job_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_data;
    logic                 res_last;
    logic                 busy;
    logic                 scn_start;
    logic [63:0]          scn_threshold;
    logic [23:0][31:0]    scn_blobby;
    logic                 scn_dispatching;
    logic                 scn_evaluating;
    logic                 scn_found;
    logic                 scn_ready;
    logic [31:0]          scn_nonce;
    logic [49:0][31:0]    scn_hash;

    // stub controls
    logic                 stub_hold;
    logic                 stub_pulse;
    logic [7:0]           stub_busy;
    logic [1:0]           sph;
    logic [7:0]           scnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] rw [0:63];
    bit          rl [0:63];
    int          rn;
    int          viol;

    always #5 clk = ~clk;

    sha3_job_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_data        (job_data),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_last        (res_last),
        .busy            (busy),
        .scn_start       (scn_start),
        .scn_threshold   (scn_threshold),
        .scn_blobby      (scn_blobby),
        .scn_dispatching (scn_dispatching),
        .scn_evaluating  (scn_evaluating),
        .scn_found       (scn_found),
        .scn_ready       (scn_ready),
        .scn_nonce       (scn_nonce),
        .scn_hash        (scn_hash)
    );

    // Scanner stub: idle(ready) -> optional ready pulse -> dispatching for stub_busy cycles -> idle.
    always @(posedge clk) begin
        if (rst) begin
            sph  <= 2'd0;
            scnt <= 8'd0;
        end else begin
            case (sph)
                2'd0: if (scn_start && scn_ready) begin
                    sph  <= stub_pulse ? 2'd1 : 2'd2;
                    scnt <= stub_busy;
                end
                2'd1: sph <= 2'd2;
                2'd2: if (scnt <= 8'd1) sph <= 2'd0; else scnt <= scnt - 8'd1;
                default: sph <= 2'd0;
            endcase
        end
    end
    assign scn_ready       = (sph == 2'd0) ? !stub_hold : (sph == 2'd1);
    assign scn_dispatching = (sph == 2'd2);
    assign scn_evaluating  = scn_dispatching;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_job(input logic [31:0] base);
        for (int i = 0; i < 26; i++) begin
            int t;
            t = 0;
            job_valid = 1'b1;
            job_data  = base + 32'(i);
            while (!job_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!job_ready) chk("job_ready_timeout", 64'(job_ready), 64'd1);
            @(negedge clk);
        end
        job_valid = 1'b0;
        job_data  = '0;
    endtask

    // Collects one result record; bp toggles res_ready every other cycle.
    task automatic get_result(input bit bp);
        int t;
        int guard;
        bit done;
        bit held;
        logic [31:0] hd;
        logic hl;
        t = 0; guard = 0; done = 0; held = 0; rn = 0; viol = 0;
        hd = '0; hl = 1'b0;
        res_ready = 1'b0;
        while (!res_valid && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid) begin
            chk("res_valid_timeout", 64'(res_valid), 64'd1);
            return;
        end
        while (!done && guard < 400 && rn < 64) begin
            res_ready = bp ? ((guard % 2) == 1) : 1'b1;
            if (res_valid) begin
                if (res_ready) begin
                    rw[rn] = res_data;
                    rl[rn] = res_last;
                    rn++;
                    if (res_last) done = 1;
                end else begin
                    hd = res_data; hl = res_last; held = 1;
                end
            end
            @(negedge clk);
            guard++;
            if (held && (res_data !== hd || res_last !== hl || res_valid !== 1'b1)) viol++;
            held = 0;
        end
        res_ready = 1'b0;
        if (!done) chk("res_last_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_record(input int sc, input bit bp,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        int early;
        get_result(bp);
        early = 0;
        for (int i = 0; i < rn - 1; i++) if (rl[i]) early++;
        chk($sformatf("s%0d_len", sc), 64'(rn), 64'(NW));
        chk($sformatf("s%0d_w0", sc), 64'(rw[0]), 64'(e0));
        chk($sformatf("s%0d_w1", sc), 64'(rw[1]), 64'(e1));
        chk($sformatf("s%0d_w2", sc), 64'(rw[2]), 64'(e2));
`ifdef SHA3_JOB_SEQUENCER_HASH_READBACK_EN
        for (int i = 3; i < 53; i++)
            chk($sformatf("s%0d_hash%0d", sc, i - 3), 64'(rw[i]), 64'(32'hA5000000 + 32'(i - 3)));
`endif
        chk($sformatf("s%0d_last_final", sc), 64'(rl[(rn > 0) ? rn - 1 : 0]), 64'd1);
        chk($sformatf("s%0d_last_early", sc), 64'(early), 64'd0);
        chk($sformatf("s%0d_stall_stable", sc), 64'(viol), 64'd0);
        chk($sformatf("s%0d_post_busy", sc), 64'(busy), 64'd0);
        chk($sformatf("s%0d_post_job_ready", sc), 64'(job_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; job_valid = 1'b0; job_data = '0; res_ready = 1'b0;
        stub_hold = 1'b0; stub_pulse = 1'b0; stub_busy = 8'd10;
        scn_found = 1'b0; scn_nonce = '0;
        for (int i = 0; i < 50; i++) scn_hash[i] = 32'hA5000000 + 32'(i);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_job_ready", 64'(job_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_last",  64'(res_last),  64'd0);
        chk("rst_scn_start", 64'(scn_start), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_res_data",  64'(res_data),  64'd0);
        chk("rst_threshold", scn_threshold,  64'd0);
        chk("rst_blobby0",   64'(scn_blobby[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: found, 10 busy cycles
        stub_busy = 8'd10; scn_found = 1'b1; scn_nonce = 32'h1234;
        load_job(32'h100);
        chk("s1_start_early", 64'(scn_start), 64'd1);
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_job_ready_low", 64'(job_ready), 64'd0);
        chk("s1_blobby5", 64'(scn_blobby[5]), 64'h105);
        chk("s1_blobby23", 64'(scn_blobby[23]), 64'h117);
        chk("s1_threshold", scn_threshold, 64'h00000119_00000118);
        check_record(1, 1'b0, 32'd1, 32'h1234, 32'd11);

        // 2: miss
        stub_busy = 8'd4; scn_found = 1'b0; scn_nonce = 32'h5555;
        load_job(32'h300);
        check_record(2, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd5);

        // 3: ready pulse right after capture must not complete the scan
        stub_busy = 8'd6; stub_pulse = 1'b1; scn_found = 1'b1; scn_nonce = 32'hBEEF;
        load_job(32'h400);
        check_record(3, 1'b0, 32'd1, 32'hBEEF, 32'd8);
        stub_pulse = 1'b0;

        // 4: scanner not ready for 5 cycles in ISSUE
        stub_busy = 8'd3; stub_hold = 1'b1; scn_found = 1'b1; scn_nonce = 32'h7;
        load_job(32'h500);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s4_start_low%0d", i), 64'(scn_start), 64'd0);
            @(negedge clk);
        end
        stub_hold = 1'b0;
        #1;
        chk("s4_start_cycle6", 64'(scn_start), 64'd1);
        check_record(4, 1'b0, 32'd1, 32'h7, 32'd4);

        // 5: result backpressure
        stub_busy = 8'd2; scn_found = 1'b1; scn_nonce = 32'hCAFE;
        load_job(32'h600);
        check_record(5, 1'b1, 32'd1, 32'hCAFE, 32'd3);

        // 6: reset in WAIT_DONE
        stub_busy = 8'd20; scn_found = 1'b1; scn_nonce = 32'h99;
        load_job(32'h700);
        repeat (5) @(negedge clk);
        chk("s6_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_busy", 64'(busy), 64'd0);
        chk("s6_job_ready", 64'(job_ready), 64'd1);
        chk("s6_res_valid", 64'(res_valid), 64'd0);
        chk("s6_blobby0", 64'(scn_blobby[0]), 64'd0);
        chk("s6_threshold", scn_threshold, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // recovery job after reset
        stub_busy = 8'd1; scn_found = 1'b0; scn_nonce = 32'h0;
        load_job(32'h200);
        chk("s7_blobby0", 64'(scn_blobby[0]), 64'h200);
        check_record(7, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
